// File: rtl/mem_responder.sv
// Memory-side responder: tagged read/write requests are queued in order, serviced one
// at a time against a word-addressed array after a fixed latency, and answered with a ready pulse.
module mem_responder #(
    parameter int DEPTH     = 4,
    parameter int LATENCY   = 2,
    parameter int MEM_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr_in,
    input  logic [31:0] data_in,
    input  logic        rw_in,
    input  logic [3:0]  id_in,
    input  logic        valid_in,
    output logic [31:0] data_out,
    output logic [3:0]  id_out,
    output logic        ready_out,
    output logic        stall_out,
    output logic        overflow_err,
    output logic [1:0]  fsm_state
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(MEM_WORDS);
    localparam int LW = $clog2(LATENCY + 1);
    localparam logic [CW-1:0] FULL     = CW'(DEPTH);
    localparam logic [LW-1:0] LAT_LOAD = LW'(LATENCY);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state;
    logic [LW-1:0] cnt;

    // Request FIFO storage; only the word index of the address is kept.
    logic [IW-1:0] q_idx  [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic          q_rw   [DEPTH];
    logic [3:0]    q_id   [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    // Request currently being serviced.
    logic [IW-1:0] s_idx;
    logic [31:0]   s_data;
    logic          s_rw;
    logic [3:0]    s_id;

    logic [31:0] mem [MEM_WORDS];

    logic          push;
    logic          pop;
    logic          fire;
    logic [IW-1:0] idx_in;
    logic          unused_addr_bits;

    // Upper and byte-offset address bits are deliberately ignored, giving modulo aliasing.
    assign idx_in           = addr_in[IW+1:2];
    assign unused_addr_bits = ^{addr_in[31:IW+2], addr_in[1:0]};

    // Stall comes from the pre-edge count, so a full FIFO drops even on a popping edge.
    assign stall_out = (count == FULL);
    assign push      = valid_in && !stall_out;
    assign pop       = ((state == IDLE) || (state == RESP)) && (count != '0);
    assign fire      = (state == WAIT) && (cnt == LW'(1));
    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (push) begin
            q_idx[tail]  <= idx_in;
            q_data[tail] <= data_in;
            q_rw[tail]   <= rw_in;
            q_id[tail]   <= id_in;
        end
    end

    always_ff @(posedge clk) begin
        if (fire && s_rw) begin
            mem[s_idx] <= s_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            overflow_err <= 1'b0;
        end else begin
            if (push) tail <= tail + PTR_ONE;
            if (pop)  head <= head + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
            if (valid_in && stall_out) overflow_err <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            s_idx     <= '0;
            s_data    <= '0;
            s_rw      <= 1'b0;
            s_id      <= '0;
            data_out  <= '0;
            id_out    <= '0;
            ready_out <= 1'b0;
        end else begin
            ready_out <= 1'b0;
            unique case (state)
                IDLE, RESP: begin
                    if (pop) begin
                        s_idx  <= q_idx[head];
                        s_data <= q_data[head];
                        s_rw   <= q_rw[head];
                        s_id   <= q_id[head];
                        cnt    <= LAT_LOAD;
                        state  <= WAIT;
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (fire) begin
                        // Reads see the array as held now, so earlier queued writes are visible.
                        data_out  <= s_rw ? s_data : mem[s_idx];
                        id_out    <= s_id;
                        ready_out <= 1'b1;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - LW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
